// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter (with helper alu_arbiter_alu)
// Purpose  : Two requesters share one 32-bit ALU. A round-robin arbiter
//            grants at most one request per cycle into a single registered
//            response slot that drains under valid/ready flow control.
// Ports    : clk, reset (sync, active-high)
//            r0_/r1_ valid, ready, control[3:0], a[31:0], b[31:0]
//            rsp_valid, rsp_ready, rsp_id, rsp_result[31:0], rsp_zero,
//            rsp_err, ops_done[15:0]
// Revision : 1.0 - initial release
// ============================================================================

module alu_arbiter_alu (
  input  logic [3:0]  control,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        err
);
  always_comb begin
    result = '0;
    err    = 1'b0;
    case (control)
      4'd0:    result = a + b;
      4'd1:    result = a - b;
      4'd2:    result = a | b;
      4'd3:    result = a & b;
      4'd4:    result = a ^ b;
      4'd5:    result = a << b[4:0];
      4'd6:    result = a >> b[4:0];
      4'd7:    result = $unsigned($signed(a) >>> b[4:0]);
      4'd8:    result = {31'b0, ($signed(a) < $signed(b))};
      4'd9:    result = {31'b0, (a < b)};
      default: err = 1'b1;  // opcodes 10-15: result stays 0
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int PRIO_INIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [3:0]  r0_control,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [3:0]  r1_control,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic [15:0] ops_done
);
  localparam logic PRIO_RST = (PRIO_INIT != 0);

  typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} slot_t;

  slot_t       state;
  logic        prio;       // index of the requester that wins a tie
  logic        slot_free;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic [3:0]  alu_control;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_err;

  assign rsp_valid = (state == FULL);

  // The slot can take a new result if it is empty or being drained right now.
  // Reset blocks all grants so nothing is accepted while it is asserted.
  always_comb begin
    slot_free = !rsp_valid || rsp_ready;
    grant0    = !reset && slot_free && r0_valid && (!r1_valid || !prio);
    grant1    = !reset && slot_free && r1_valid && (!r0_valid ||  prio);
    accept    = grant0 || grant1;
  end

  assign r0_ready = grant0;
  assign r1_ready = grant1;

  // Operand steering for the single shared ALU.
  always_comb begin
    alu_control = grant1 ? r1_control : r0_control;
    alu_a       = grant1 ? r1_a       : r0_a;
    alu_b       = grant1 ? r1_b       : r0_b;
  end

  alu_arbiter_alu u_alu (
    .control (alu_control),
    .a       (alu_a),
    .b       (alu_b),
    .result  (alu_result),
    .err     (alu_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      prio       <= PRIO_RST;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      ops_done   <= '0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        ops_done <= ops_done + 16'd1;
      end
      if (accept) begin
        state      <= FULL;
        prio       <= grant0;  // priority passes to the requester not granted
        rsp_id     <= grant1;
        rsp_result <= alu_result;
        rsp_zero   <= (alu_result == 32'd0);
        rsp_err    <= alu_err;
      end else if (rsp_ready) begin
        state <= EMPTY;
      end
    end
  end
endmodule

`default_nettype wire
